// File: rtl/seq_div_32_if.sv
// Operand/result bundle for the iterative divider: request side on the master,
// datapath side on the slave.
interface seq_div_32_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic             SnU;
    logic [WIDTH-1:0] DIVIDEND;
    logic [WIDTH-1:0] DIVISOR;
    logic [WIDTH-1:0] QUOTIENT;
    logic [WIDTH-1:0] REMAINDER;
    logic             BUSY;
    logic             DONE;
    logic             DIV_BY_ZERO;

    modport master (
        output START, SnU, DIVIDEND, DIVISOR,
        input  QUOTIENT, REMAINDER, BUSY, DONE, DIV_BY_ZERO
    );

    modport slave (
        input  START, SnU, DIVIDEND, DIVISOR,
        output QUOTIENT, REMAINDER, BUSY, DONE, DIV_BY_ZERO
    );
endinterface

// File: rtl/seq_div_32.sv
// Iterative restoring divider: one quotient bit per clock on a single subtract
// stage, with sign fixup afterwards for signed DIV/REM.
module seq_div_32 #(
    parameter int WIDTH = 32
) (
    input logic          CLK,
    input logic          RST,
    seq_div_32_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        sIdle,
        sCalc,
        sFix,
        sDone
    } state_t;

    state_t           stateReg;
    logic [CW-1:0]    countReg;
    logic [WIDTH-1:0] qReg;
    logic [WIDTH-1:0] prReg;
    logic [WIDTH-1:0] divisorReg;
    logic             negQReg;
    logic             negRReg;
    logic             zeroReg;
    logic [WIDTH-1:0] quotientReg;
    logic [WIDTH-1:0] remainderReg;
    logic             busyReg;
    logic             doneReg;
    logic             divByZeroReg;

    logic             dividendNeg;
    logic             divisorNeg;
    logic [WIDTH-1:0] dividendMag;
    logic [WIDTH-1:0] divisorMag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             carryOut;

    assign dividendNeg = bus.SnU & bus.DIVIDEND[WIDTH-1];
    assign divisorNeg  = bus.SnU & bus.DIVISOR[WIDTH-1];
    assign dividendMag = dividendNeg ? -bus.DIVIDEND : bus.DIVIDEND;
    assign divisorMag  = divisorNeg  ? -bus.DIVISOR  : bus.DIVISOR;

    // The partial remainder stays below the divisor, so the (WIDTH+1)-bit
    // difference never overflows and its sign bit is exactly the borrow.
    assign shifted  = {prReg, qReg[WIDTH-1]};
    assign diff     = shifted - {1'b0, divisorReg};
    assign carryOut = ~diff[WIDTH];

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateReg     <= sIdle;
            countReg     <= '0;
            qReg         <= '0;
            prReg        <= '0;
            divisorReg   <= '0;
            negQReg      <= 1'b0;
            negRReg      <= 1'b0;
            zeroReg      <= 1'b0;
            quotientReg  <= '0;
            remainderReg <= '0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
            divByZeroReg <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (stateReg)
                sIdle, sDone: begin
                    stateReg <= sIdle;
                    if (bus.START) begin
                        busyReg      <= 1'b1;
                        divByZeroReg <= 1'b0;
                        prReg        <= '0;
                        countReg     <= CW'(WIDTH - 1);
                        divisorReg   <= divisorMag;
                        if (bus.DIVISOR == '0) begin
                            // Raw dividend parks in qReg so FIX can return it untouched.
                            zeroReg  <= 1'b1;
                            qReg     <= bus.DIVIDEND;
                            negQReg  <= 1'b0;
                            negRReg  <= 1'b0;
                            stateReg <= sFix;
                        end else begin
                            zeroReg  <= 1'b0;
                            qReg     <= dividendMag;
                            negQReg  <= dividendNeg ^ divisorNeg;
                            negRReg  <= dividendNeg;
                            stateReg <= sCalc;
                        end
                    end
                end
                sCalc: begin
                    prReg <= carryOut ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    qReg  <= {qReg[WIDTH-2:0], carryOut};
                    if (countReg == '0) begin
                        stateReg <= sFix;
                    end else begin
                        countReg <= countReg - CW'(1);
                    end
                end
                sFix: begin
                    if (zeroReg) begin
                        quotientReg  <= '1;
                        remainderReg <= qReg;
                        divByZeroReg <= 1'b1;
                    end else begin
                        quotientReg  <= negQReg ? -qReg  : qReg;
                        remainderReg <= negRReg ? -prReg : prReg;
                    end
                    busyReg  <= 1'b0;
                    doneReg  <= 1'b1;
                    stateReg <= sDone;
                end
                default: begin
                    stateReg <= sIdle;
                end
            endcase
        end
    end

    assign bus.QUOTIENT    = quotientReg;
    assign bus.REMAINDER   = remainderReg;
    assign bus.BUSY        = busyReg;
    assign bus.DONE        = doneReg;
    assign bus.DIV_BY_ZERO = divByZeroReg;
endmodule

// File: tb/tb_seq_div_32.sv
// Directed bench for seq_div_32: hand-computed quotients/remainders, latency,
// handshake and reset behaviour.
module tb_seq_div_32;
    localparam int WIDTH = 32;

    logic CLK = 1'b0;
    logic RST;
    int   testsRun = 0;
    int   testsFailed = 0;

    seq_div_32_if #(.WIDTH(WIDTH)) bus ();

    seq_div_32 #(.WIDTH(WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // All driving and sampling happens 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulseStart(input logic snu, input logic [31:0] a, input logic [31:0] b);
        bus.SnU      = snu;
        bus.DIVIDEND = a;
        bus.DIVISOR  = b;
        bus.START    = 1'b1;
        tick();
        bus.START    = 1'b0;
    endtask

    // Counts edges after the accepting edge until DONE; bounded so a stuck DUT still ends.
    task automatic waitDone(output int edges, output int busyLow);
        edges   = 0;
        busyLow = 0;
        while (bus.DONE !== 1'b1 && edges < 100) begin
            if (bus.BUSY !== 1'b1) busyLow++;
            tick();
            edges++;
        end
    endtask

    task automatic runOp(input string tag, input logic snu, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expQ, input logic [31:0] expR, input logic expDbz,
                         input int expEdges);
        int edges;
        int busyLow;
        pulseStart(snu, a, b);
        waitDone(edges, busyLow);
        check({tag, " latency"}, edges, expEdges);
        check({tag, " busy"}, busyLow, 0);
        check({tag, " quotient"}, bus.QUOTIENT, expQ);
        check({tag, " remainder"}, bus.REMAINDER, expR);
        check({tag, " div_by_zero"}, bus.DIV_BY_ZERO, expDbz);
        $display("[TB] %s: snu=%0d a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h dbz=%0d edges=%0d",
                 tag, snu, a, b, bus.QUOTIENT, bus.REMAINDER, bus.DIV_BY_ZERO, edges);
    endtask

    initial begin
        int edges;
        int busyLow;
        int doneSeen;

        RST          = 1'b1;
        bus.START    = 1'b0;
        bus.SnU      = 1'b0;
        bus.DIVIDEND = '0;
        bus.DIVISOR  = '0;
        repeat (3) tick();
        check("reset quotient", bus.QUOTIENT, 0);
        check("reset remainder", bus.REMAINDER, 0);
        check("reset busy", bus.BUSY, 0);
        check("reset done", bus.DONE, 0);
        check("reset dbz", bus.DIV_BY_ZERO, 0);
        RST = 1'b0;
        tick();

        // Unsigned 100/7, then confirm DONE is a single-cycle pulse.
        runOp("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        tick();
        check("u100/7 done pulse", bus.DONE, 0);
        check("u100/7 idle busy", bus.BUSY, 0);

        runOp("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        runOp("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        runOp("s-3/10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, 1'b0, 33);

        // Divide by zero takes the short path and clears on the next operation.
        runOp("u5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        runOp("u9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);
        runOp("s-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);

        runOp("smin/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        runOp("umax/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        runOp("u3/0x80000000", 1'b0, 32'd3, 32'h8000_0000, 32'd0, 32'd3, 1'b0, 33);

        // START during CALC is ignored: latency and result belong to the first request.
        pulseStart(1'b0, 32'd100, 32'd7);
        repeat (10) tick();
        pulseStart(1'b0, 32'd1000, 32'd3);
        waitDone(edges, busyLow);
        check("ignored start latency", edges, 22);
        check("ignored start busy", busyLow, 0);
        check("ignored start quotient", bus.QUOTIENT, 14);
        check("ignored start remainder", bus.REMAINDER, 2);
        $display("[TB] busy-start: q=0x%08h r=0x%08h edges=%0d", bus.QUOTIENT, bus.REMAINDER, edges);

        // START in the DONE cycle is accepted with no bubble.
        runOp("b2b 50/5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

        // Reset mid-CALC aborts with no DONE afterwards.
        pulseStart(1'b0, 32'd100, 32'd7);
        repeat (10) tick();
        RST = 1'b1;
        tick();
        check("midreset busy", bus.BUSY, 0);
        check("midreset quotient", bus.QUOTIENT, 0);
        check("midreset remainder", bus.REMAINDER, 0);
        check("midreset done", bus.DONE, 0);
        check("midreset dbz", bus.DIV_BY_ZERO, 0);
        RST = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            tick();
            if (bus.DONE === 1'b1) doneSeen++;
        end
        check("midreset no done", doneSeen, 0);
        $display("[TB] mid-calc reset: done pulses after reset=%0d", doneSeen);

        runOp("fresh 50/5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
